// File: rtl/stack_alu_sequencer_if.sv
// Bus bundle between the stack ALU sequencer, its token producer,
// the attached stack ALU and the result consumer.
interface stack_alu_sequencer_if #(
    parameter int N = 8
);
    // token channel
    logic         tok_valid;
    logic         tok_ready;
    logic [1:0]   tok_kind;
    logic [N-1:0] tok_data;

    // stack ALU command / response
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_in;
    logic [N-1:0] alu_out;
    logic         alu_overflow;

    // result channel
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_overflow;
    logic         err;

    // sequencer side
    modport master (
        input  tok_valid, tok_kind, tok_data,
        input  alu_out, alu_overflow,
        input  res_ready,
        output tok_ready,
        output alu_opcode, alu_in,
        output res_valid, res_data, res_overflow, err
    );

    // environment side: token source, ALU and result sink
    modport slave (
        output tok_valid, tok_kind, tok_data,
        output alu_out, alu_overflow,
        output res_ready,
        input  tok_ready,
        input  alu_opcode, alu_in,
        input  res_valid, res_data, res_overflow, err
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Stack ALU sequencer: turns a postfix token stream into stack ALU
// commands, tracks stack depth, rejects malformed expressions by draining
// the ALU stack, and hands the final result to a consumer.
module stack_alu_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    stack_alu_sequencer_if.master bus
);
    // depth counter needs to hold 0..DEPTH and compare against 2
    localparam int DW = (DEPTH < 3) ? 2 : $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;

    typedef enum logic [2:0] {
        ACCEPT,
        POP,
        CAPT,
        DONE,
        DRAIN
    } state_t;

    state_t        state;
    logic [DW-1:0] depth;
    logic [2:0]    opcode;
    logic [N-1:0]  alu_in_q;
    logic          ready;
    logic          res_valid_q;
    logic [N-1:0]  res_data_q;
    logic          res_ovf_q;
    logic          err_q;
    logic          sticky_ovf;

    logic          take;
    logic          bad;
    logic          arith;

    assign take  = bus.tok_valid & ready;
    assign arith = (opcode == OP_ADD) || (opcode == OP_MUL);

    // Classify the offered token against the current stack depth.
    always_comb begin
        bad = 1'b0;
        case (bus.tok_kind)
            K_OPND:       bad = (depth == DEPTH_MAX);
            K_ADD, K_MUL: bad = (depth < DW'(2));
            default:      bad = (depth != DW'(1));
        endcase
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCEPT;
            depth       <= '0;
            opcode      <= OP_NOP;
            alu_in_q    <= '0;
            ready       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
            sticky_ovf  <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            opcode <= OP_NOP;
            // flag reflects the add/multiply issued during the cycle just ending
            if (arith && bus.alu_overflow)
                sticky_ovf <= 1'b1;

            case (state)
                ACCEPT: begin
                    ready <= 1'b1;
                    if (take) begin
                        if (bad) begin
                            // malformed: issue nothing for this token, then
                            // pop whatever is on the ALU stack
                            err_q  <= 1'b1;
                            ready  <= 1'b0;
                            state  <= DRAIN;
                            opcode <= (depth != '0) ? OP_POP : OP_NOP;
                        end else begin
                            case (bus.tok_kind)
                                K_OPND: begin
                                    opcode   <= OP_PUSH;
                                    alu_in_q <= bus.tok_data;
                                    depth    <= depth + DW'(1);
                                end
                                K_ADD: begin
                                    opcode <= OP_ADD;
                                    depth  <= depth - DW'(1);
                                end
                                K_MUL: begin
                                    opcode <= OP_MUL;
                                    depth  <= depth - DW'(1);
                                end
                                default: begin
                                    // end: pop the single remaining entry
                                    opcode <= OP_POP;
                                    depth  <= '0;
                                    ready  <= 1'b0;
                                    state  <= POP;
                                end
                            endcase
                        end
                    end
                end

                POP: begin
                    state <= CAPT;
                end

                CAPT: begin
                    // alu_out now holds the popped result
                    res_data_q  <= bus.alu_out;
                    res_valid_q <= 1'b1;
                    res_ovf_q   <= sticky_ovf;
                    state       <= DONE;
                end

                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        depth       <= '0;
                        sticky_ovf  <= 1'b0;
                        ready       <= 1'b1;
                        state       <= ACCEPT;
                    end
                end

                DRAIN: begin
                    // depth counts pops still to be shown on alu_opcode,
                    // including the one visible this cycle
                    if (depth <= DW'(1)) begin
                        depth      <= '0;
                        sticky_ovf <= 1'b0;
                        ready      <= 1'b1;
                        state      <= ACCEPT;
                    end else begin
                        depth  <= depth - DW'(1);
                        opcode <= OP_POP;
                    end
                end

                default: begin
                    state <= ACCEPT;
                end
            endcase
        end
    end

    assign bus.tok_ready    = ready;
    assign bus.alu_opcode   = opcode;
    assign bus.alu_in       = alu_in_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_overflow = res_ovf_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU, result scoreboard,
// opcode/err monitors, a vector table and hand-written corner sequences.
module tb_stack_alu_sequencer;
    localparam int N     = 8;
    localparam int DEPTH = 8;

    localparam logic [9:0] T_ADD = 10'h100;
    localparam logic [9:0] T_MUL = 10'h200;
    localparam logic [9:0] T_END = 10'h300;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stack_alu_sequencer_if #(.N(N)) bus ();

    stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural stack ALU ----------------
    logic [N-1:0] stk [DEPTH];
    int           sp;
    logic         misuse = 1'b0;
    logic [N-1:0] a_top, b_top;
    logic [N:0]   sum;
    logic [2*N-1:0] prod;

    always_comb begin
        a_top = (sp >= 1) ? stk[sp-1] : '0;
        b_top = (sp >= 2) ? stk[sp-2] : '0;
        sum   = {1'b0, b_top} + {1'b0, a_top};
        prod  = (2*N)'(b_top) * (2*N)'(a_top);
        bus.alu_overflow = 1'b0;
        if (bus.alu_opcode == 3'b100) bus.alu_overflow = sum[N];
        if (bus.alu_opcode == 3'b101) bus.alu_overflow = |prod[2*N-1:N];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp          <= 0;
            bus.alu_out <= '0;
        end else begin
            case (bus.alu_opcode)
                3'b110: if (sp >= DEPTH) misuse <= 1'b1;
                        else begin stk[sp] <= bus.alu_in; sp <= sp + 1; bus.alu_out <= bus.alu_in; end
                3'b100: if (sp < 2) misuse <= 1'b1;
                        else begin stk[sp-2] <= sum[N-1:0]; sp <= sp - 1; bus.alu_out <= sum[N-1:0]; end
                3'b101: if (sp < 2) misuse <= 1'b1;
                        else begin stk[sp-2] <= prod[N-1:0]; sp <= sp - 1; bus.alu_out <= prod[N-1:0]; end
                3'b111: if (sp < 1) misuse <= 1'b1;
                        else begin bus.alu_out <= stk[sp-1]; sp <= sp - 1; end
                default: ;
            endcase
        end
    end

    // ---------------- monitors ----------------
    typedef struct { logic [N-1:0] data; logic ovf; } res_t;
    res_t sb[$];
    res_t exp_r;

    typedef struct { logic [2:0] op; int cyc; } oplog_t;
    oplog_t ops[$];
    int cyc     = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.alu_opcode != 3'b000) ops.push_back('{bus.alu_opcode, cyc});
        if (bus.err) err_cnt <= err_cnt + 1;
    end

    // scoreboard: compare a result on the cycle it is handed over
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %0d expected none", bus.res_data);
            end else begin
                exp_r = sb.pop_front();
                check("res_data", 32'(bus.res_data), 32'(exp_r.data));
                check("res_overflow", 32'(bus.res_overflow), 32'(exp_r.ovf));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_tok(input logic [9:0] t);
        int w;
        w = 0;
        bus.tok_valid = 1'b1;
        bus.tok_kind  = t[9:8];
        bus.tok_data  = t[7:0];
        @(negedge clk);
        while (!bus.tok_ready && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) begin
            tests++; fails++;
            $display("FAIL tok_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && bus.tok_ready) && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) begin
            tests++; fails++;
            $display("FAIL %s_idle_timeout: got busy expected idle", name);
        end
        @(posedge clk); #1;
    endtask

    function automatic int count_op(input int from, input logic [2:0] op);
        int c;
        c = 0;
        for (int i = from; i < ops.size(); i++) if (ops[i].op == op) c++;
        return c;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int           n;
        logic [5:0][9:0] toks;
        logic         exp_err;
        logic [N-1:0] exp_data;
        logic         exp_ovf;
        int           exp_pops;
    } vec_t;

    function automatic logic [5:0][9:0] seq6(input logic [9:0] a, b, c, d, e, f);
        seq6[0] = a; seq6[1] = b; seq6[2] = c; seq6[3] = d; seq6[4] = e; seq6[5] = f;
    endfunction

    vec_t vecs [11];

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int o0, e0, w, cnt;
        logic ok;

        vecs[0]  = '{4, seq6(10'd5, 10'd3, T_ADD, T_END, 0, 0),        1'b0, 8'd8,   1'b0, 1};
        vecs[1]  = '{6, seq6(10'd5, 10'd3, T_ADD, 10'd2, T_MUL, T_END), 1'b0, 8'd16,  1'b0, 1};
        vecs[2]  = '{4, seq6(10'd200, 10'd100, T_ADD, T_END, 0, 0),    1'b0, 8'd44,  1'b1, 1};
        vecs[3]  = '{6, seq6(10'd2, 10'd3, 10'd4, T_MUL, T_ADD, T_END), 1'b0, 8'd14,  1'b0, 1};
        vecs[4]  = '{6, seq6(10'd16, 10'd16, T_MUL, 10'd1, T_ADD, T_END), 1'b0, 8'd1, 1'b1, 1};
        vecs[5]  = '{4, seq6(10'd20, 10'd20, T_MUL, T_END, 0, 0),      1'b0, 8'd144, 1'b1, 1};
        vecs[6]  = '{2, seq6(10'd1, T_END, 0, 0, 0, 0),                1'b0, 8'd1,   1'b0, 1};
        vecs[7]  = '{3, seq6(10'd3, 10'd4, T_END, 0, 0, 0),            1'b1, 8'd0,   1'b0, 2};
        vecs[8]  = '{1, seq6(T_END, 0, 0, 0, 0, 0),                    1'b1, 8'd0,   1'b0, 0};
        vecs[9]  = '{1, seq6(T_ADD, 0, 0, 0, 0, 0),                    1'b1, 8'd0,   1'b0, 0};
        vecs[10] = '{2, seq6(10'd255, T_END, 0, 0, 0, 0),              1'b0, 8'd255, 1'b0, 1};

        rst_n = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_kind  = 2'b00;
        bus.tok_data  = '0;
        bus.res_ready = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tok_ready", 32'(bus.tok_ready), 0);
        check("rst_opcode", 32'(bus.alu_opcode), 0);
        check("rst_alu_in", 32'(bus.alu_in), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_res_ovf", 32'(bus.res_overflow), 0);
        check("rst_err", 32'(bus.err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first_tok_ready", 32'(bus.tok_ready), 1);
        @(posedge clk); #1;

        // 5 3 add end: opcode stream and result latency
        o0 = ops.size();
        sb.push_back('{8'd8, 1'b0});
        send_tok(10'd5); send_tok(10'd3); send_tok(T_ADD); send_tok(T_END);
        @(negedge clk); check("lat_pop_cycle", 32'(bus.res_valid), 0);
        @(negedge clk); check("lat_capt_cycle", 32'(bus.res_valid), 0);
        @(negedge clk); check("lat_res_valid", 32'(bus.res_valid), 1);
        check("b2b_op_count", ops.size() - o0, 4);
        if (ops.size() - o0 == 4) begin
            check("b2b_op0", 32'(ops[o0].op), 3'b110);
            check("b2b_op1", 32'(ops[o0+1].op), 3'b110);
            check("b2b_op2", 32'(ops[o0+2].op), 3'b100);
            check("b2b_op3", 32'(ops[o0+3].op), 3'b111);
            check("b2b_no_bubbles", ops[o0+3].cyc - ops[o0].cyc, 3);
        end
        wait_idle("b2b");

        // result held while consumer stalls
        bus.res_ready = 1'b0;
        sb.push_back('{8'd16, 1'b0});
        send_tok(10'd5); send_tok(10'd3); send_tok(T_ADD);
        send_tok(10'd2); send_tok(T_MUL); send_tok(T_END);
        w = 0;
        @(negedge clk);
        while (!bus.res_valid && w < 50) begin @(negedge clk); w++; end
        check("hold_res_valid_seen", 32'(bus.res_valid), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(bus.res_valid), 1);
            check("hold_res_data", 32'(bus.res_data), 16);
        end
        @(posedge clk); #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_cleared", 32'(bus.res_valid), 0);
        wait_idle("hold");

        // table-driven expressions
        for (int i = 0; i < 11; i++) begin
            o0 = ops.size();
            e0 = err_cnt;
            for (int j = 0; j < vecs[i].n; j++) begin
                if (vecs[i].toks[j] == T_END && !vecs[i].exp_err)
                    sb.push_back('{vecs[i].exp_data, vecs[i].exp_ovf});
                send_tok(vecs[i].toks[j]);
            end
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), err_cnt - e0, 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_pops", i), count_op(o0, 3'b111), vecs[i].exp_pops);
        end

        // operator underflow: 4 add -> err, one drain pop, then 7 end
        o0 = ops.size();
        e0 = err_cnt;
        send_tok(10'd4); send_tok(T_ADD);
        wait_idle("uflow");
        check("uflow_err_pulse", err_cnt - e0, 1);
        check("uflow_no_add", count_op(o0, 3'b100), 0);
        check("uflow_pops", count_op(o0, 3'b111), 1);
        sb.push_back('{8'd7, 1'b0});
        send_tok(10'd7); send_tok(T_END);
        wait_idle("uflow_recover");

        // stack full: 9 operands -> 8 pushes, err, 8 back-to-back pops
        o0 = ops.size();
        e0 = err_cnt;
        for (int k = 1; k <= 9; k++) send_tok(10'(k));
        cnt = 0;
        @(negedge clk);
        while (!bus.tok_ready && cnt < 50) begin cnt++; @(negedge clk); end
        check("full_ready_low_cycles", cnt, 8);
        check("full_err_pulse", err_cnt - e0, 1);
        check("full_pushes", count_op(o0, 3'b110), 8);
        check("full_pops", count_op(o0, 3'b111), 8);
        ok = (ops.size() - o0 == 16);
        if (ok) for (int k = 1; k < 8; k++)
            if (ops[o0+8+k].op != 3'b111 || ops[o0+8+k].cyc != ops[o0+8].cyc + k) ok = 1'b0;
        check("full_pops_consecutive", 32'(ok), 1);
        @(posedge clk); #1;

        // reset mid-expression abandons it
        send_tok(10'd5); send_tok(10'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tok_ready", 32'(bus.tok_ready), 0);
        check("mid_rst_opcode", 32'(bus.alu_opcode), 0);
        check("mid_rst_alu_in", 32'(bus.alu_in), 0);
        check("mid_rst_res_valid", 32'(bus.res_valid), 0);
        check("mid_rst_res_data", 32'(bus.res_data), 0);
        check("mid_rst_res_ovf", 32'(bus.res_overflow), 0);
        check("mid_rst_err", 32'(bus.err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_ready_back", 32'(bus.tok_ready), 1);
        @(posedge clk); #1;
        sb.push_back('{8'd6, 1'b0});
        send_tok(10'd6); send_tok(T_END);
        wait_idle("post_rst");

        check("alu_misuse", 32'(misuse), 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
